// File: rtl/cd_cfg_arbiter.sv
// Round-robin arbiter sharing the clock-divider config port between N_REQ requesters.
// Issues one write at a time and follows the divider's ready drop/rise stall to report done or timeout.
module cd_cfg_arbiter #(
  parameter int N_REQ             = 3,
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int ACK_TIMEOUT       = 16,
  parameter int BUSY_TIMEOUT      = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*WIDTH_CONFIG_ADDR-1:0]   req_addr,
  input  logic [N_REQ*WIDTH_CONFIG_DATA-1:0]   req_data,
  output logic [N_REQ-1:0]                     req_ready,
  output logic [N_REQ-1:0]                     req_done,
  output logic [N_REQ-1:0]                     req_err,
  output logic [WIDTH_CONFIG_ADDR-1:0]         c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0]         c_data,
  output logic                                 c_valid,
  input  logic                                 c_ready,
  output logic                                 busy,
  output logic [$clog2(N_REQ)-1:0]             grant_id
);
  localparam int AW   = WIDTH_CONFIG_ADDR;
  localparam int DW   = WIDTH_CONFIG_DATA;
  localparam int GW   = $clog2(N_REQ);
  localparam int TMAX = (ACK_TIMEOUT > BUSY_TIMEOUT) ? ACK_TIMEOUT : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DROP, S_WAIT_RISE, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [DW-1:0] c_data_q, c_data_d;
  logic [GW-1:0] win;
  logic [GW:0]   idx;
  logic          found;

  // First requesting index at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_REQ)) idx = idx - (GW+1)'(N_REQ);
      if (!found && req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    timer_d   = timer_q;
    c_addr_d  = c_addr_q;
    c_data_d  = c_data_q;
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    c_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_ready && found) begin
          req_ready[win] = 1'b1;
          grant_d        = win;
          rr_ptr_d       = (win == GW'(N_REQ - 1)) ? '0 : win + 1'b1;
          c_addr_d       = req_addr[win*AW +: AW];
          c_data_d       = req_data[win*DW +: DW];
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        c_valid = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!c_ready) begin
          timer_d = '0;
          state_d = S_WAIT_RISE;
        end else if (timer_q >= ACK_LAST) begin
          // Divider absorbed the write without stalling.
          state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_RISE: begin
        if (c_ready) begin
          state_d = S_DONE;
        end else if (timer_q >= BUSY_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_DONE: begin
        req_done[grant_q] = 1'b1;
        state_d           = S_IDLE;
      end
      S_ERR: begin
        req_err[grant_q] = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      timer_q  <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      timer_q  <= timer_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
    end
  end

  assign c_addr   = c_addr_q;
  assign c_data   = c_data_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_cd_cfg_arbiter.sv
// Bench for cd_cfg_arbiter: directed requests against a small divider ready model,
// with queued expected writes/responses checked by an independent monitor.
module tb_cd_cfg_arbiter;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int GW = $clog2(N);
  localparam int WW = GW + AW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready, req_done, req_err;
  logic [AW-1:0]   c_addr;
  logic [DW-1:0]   c_data;
  logic            c_valid, c_ready, busy;
  logic [GW-1:0]   grant_id;

  // divider model controls
  logic mdl_ready;
  logic hold_low, stuck, nostall;
  int   drop_dly, low_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int v_cyc = 0;
  int r_cyc = 0;

  logic [WW-1:0] exp_wr_q[$];
  logic [GW:0]   exp_rsp_q[$];

  assign c_ready = mdl_ready & ~hold_low;

  cd_cfg_arbiter #(
    .N_REQ(N), .WIDTH_CONFIG_ADDR(AW), .WIDTH_CONFIG_DATA(DW),
    .ACK_TIMEOUT(16), .BUSY_TIMEOUT(4096)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .busy(busy), .grant_id(grant_id)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // divider model: ready drops drop_dly cycles after the strobe, low for low_len cycles
  initial begin
    mdl_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (c_valid && !nostall) begin
        repeat (drop_dly) @(posedge clk);
        #1 mdl_ready = 1'b0;
        if (stuck) begin
          while (stuck) @(posedge clk);
        end else begin
          repeat (low_len) @(posedge clk);
        end
        #1 mdl_ready = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [WW-1:0] w;
    logic [GW:0]   r;
    logic [N-1:0]  ed, ee;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (c_valid) begin
          v_cyc = cyc;
          if (exp_wr_q.size() == 0) fail_to("c_valid_unexpected");
          else begin
            w = exp_wr_q.pop_front();
            check("c_write", 32'({grant_id, c_addr, c_data}), 32'(w));
          end
        end
        if (|req_done || |req_err) begin
          r_cyc = cyc;
          if (exp_rsp_q.size() == 0) fail_to("rsp_unexpected");
          else begin
            r  = exp_rsp_q.pop_front();
            ed = '0;
            ee = '0;
            if (r[GW]) ee[r[GW-1:0]] = 1'b1;
            else       ed[r[GW-1:0]] = 1'b1;
            check("req_done", 32'(req_done), 32'(ed));
            check("req_err", 32'(req_err), 32'(ee));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_to("wait_idle");
  endtask

  task automatic serve(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit e, input bit push_rsp, input int hold);
    int n;
    logic blk, missed;
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    blk = 1'b0;
    missed = 1'b0;
    @(negedge clk);
    req_addr[id*AW +: AW] = a;
    req_data[id*DW +: DW] = d;
    req_valid[id] = 1'b1;
    exp_wr_q.push_back({GW'(id), a, d});
    if (push_rsp) exp_rsp_q.push_back({e, GW'(id)});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        #1 blk = blk | (|req_ready) | c_valid;
        @(negedge clk);
      end
      check("blocked_no_grant", 32'(blk), 32'd0);
      stuck = 1'b0;
      hold_low = 1'b0;
    end
    #1;
    n = 0;
    while (req_ready == '0 && n < 6000) begin
      if (c_ready) missed = 1'b1;
      @(negedge clk); #1;
      n++;
    end
    if (req_ready == '0) begin
      fail_to("grant_wait");
      req_valid = '0;
    end else begin
      check("req_ready", 32'(req_ready), 32'(oh));
      check("grant_on_first_ready", 32'(missed), 32'd0);
      @(negedge clk);
      req_valid[id] = 1'b0;
      #1 check("ready_one_cycle", 32'(req_ready), 32'd0);
    end
  endtask

  task automatic run_multi(input logic [N-1:0] mask, input int n_grants, input int order[8]);
    int k, n;
    logic [N-1:0] oh;
    for (int j = 0; j < n_grants; j++) begin
      exp_wr_q.push_back({GW'(order[j]), AW'(8 + order[j]), DW'(8'hA0 + 8'(order[j]))});
      exp_rsp_q.push_back({1'b0, GW'(order[j])});
    end
    @(negedge clk);
    req_valid = mask;
    #1;
    k = 0;
    n = 0;
    while (k < n_grants && n < 20000) begin
      if (req_ready != '0) begin
        oh = '0;
        oh[order[k]] = 1'b1;
        check("rr_grant", 32'(req_ready), 32'(oh));
        k++;
      end
      @(negedge clk);
      if (k == n_grants) req_valid = '0;
      else begin #1; n++; end
    end
    if (k < n_grants) begin
      fail_to("multi_grant_wait");
      req_valid = '0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    hold_low = 1'b0;
    stuck = 1'b0;
    nostall = 1'b0;
    drop_dly = 2;
    low_len = 10;
    repeat (3) @(negedge clk);
    #1;
    check("rst_c_valid", 32'(c_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_c_addr", 32'(c_addr), 32'd0);
    check("rst_c_data", 32'(c_data), 32'd0);
    check("rst_done_err", 32'({req_done, req_err}), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single write with a 10-cycle stall starting 2 cycles after the strobe
    serve(1, 4'h2, 8'h5A, 1'b0, 1'b1, 0);
    wait_idle(100);
    check("single_done_latency", 32'(r_cyc - v_cyc), 32'd13);
    check("single_busy_after", 32'(busy), 32'd0);

    // reset in WAIT_RISE, then requesters 1 and 2 contend from rr_ptr=0
    drop_dly = 1;
    low_len = 20;
    serve(1, 4'h7, 8'h3C, 1'b0, 1'b0, 0);
    n = 0;
    while (c_ready && n < 50) begin @(negedge clk); n++; end
    if (c_ready) fail_to("stall_start");
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_c_valid", 32'(c_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done_err", 32'({req_done, req_err}), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(8 + i);
      req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    end
    drop_dly = 2;
    low_len = 3;
    run_multi(3'b110, 2, '{1, 2, 0, 0, 0, 0, 0, 0});
    wait_idle(100);

    // fairness with every requester holding valid
    drop_dly = 1;
    low_len = 1;
    run_multi(3'b111, 6, '{0, 1, 2, 0, 1, 2, 0, 0});
    wait_idle(100);
    check("min_done_latency", 32'(r_cyc - v_cyc), 32'd3);

    // write absorbed without any stall
    nostall = 1'b1;
    serve(0, 4'hF, 8'hFF, 1'b0, 1'b1, 0);
    wait_idle(100);
    check("nostall_latency", 32'(r_cyc - v_cyc), 32'd17);
    nostall = 1'b0;

    // ready stuck low after the drop -> error, next request blocked until ready returns
    drop_dly = 1;
    stuck = 1'b1;
    serve(1, 4'h3, 8'h81, 1'b1, 1'b1, 0);
    wait_idle(6000);
    check("err_latency", 32'(r_cyc - v_cyc), 32'd4098);
    low_len = 1;
    serve(2, 4'h4, 8'h42, 1'b0, 1'b1, 5);
    wait_idle(100);

    // blocked start while c_ready is low
    hold_low = 1'b1;
    serve(0, 4'h1, 8'h11, 1'b0, 1'b1, 5);
    wait_idle(100);

    repeat (3) @(negedge clk);
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_cfg_arbiter.md
Name: cd_cfg_arbiter

Overview:
- Shares the single clock-divider configuration port (c_addr/c_data/c_valid/c_ready) between N_REQ requesters, e.g. the UART command decoder, the button/debounce handler and the boot-time default loader.
- Arbitrates round-robin and issues one config write at a time.
- Tracks the divider's reconfiguration stall: c_ready drops while the counters are held, then rises again.
- Reports completion or timeout back to the granted requester.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- WIDTH_CONFIG_ADDR, 4, config address width
- WIDTH_CONFIG_DATA, 8, config data width
- ACK_TIMEOUT, 16, cycles to wait for c_ready to drop after issue; if it never drops, the write is treated as complete
- BUSY_TIMEOUT, 4096, cycles c_ready may stay low before an error is declared

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester write request; must hold until req_ready
- req_addr  in  N_REQ*WIDTH_CONFIG_ADDR  packed addresses; requester i at slice i
- req_data  in  N_REQ*WIDTH_CONFIG_DATA  packed data; requester i at slice i
- req_ready  out  N_REQ  one-hot acceptance (combinational in IDLE)
- req_done  out  N_REQ  one-cycle completion pulse to the owning requester
- req_err  out  N_REQ  one-cycle timeout pulse to the owning requester
- c_addr  out  WIDTH_CONFIG_ADDR  to divider config
- c_data  out  WIDTH_CONFIG_DATA  to divider config
- c_valid  out  1  one-cycle write strobe
- c_ready  in  1  divider config ready (low while reconfiguring)
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(N_REQ)  index of current or last owner

Behaviour:
- Reset (async, while rst=1):
  - State=IDLE; rr_ptr=0; grant_id=0; timer=0.
  - c_addr=0, c_data=0, c_valid=0; req_done/req_err=0; busy=0.
  - Reset mid-transaction abandons it: no done/err pulse, and c_valid drops immediately.
- States: IDLE, ISSUE, WAIT_DROP, WAIT_RISE, DONE, ERR.
- IDLE:
  - If c_ready=1 and any req_valid=1, the winner g is the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready[g]=1 in that cycle; all other req_ready bits are 0.
  - At the clock edge: capture req_addr/req_data slice g into c_addr/c_data; grant_id<=g; rr_ptr<=(g+1) mod N_REQ; go to ISSUE.
  - If c_ready=0, no grant is made and req_ready stays 0.
- ISSUE: c_valid=1 for exactly one cycle; timer<=0; go to WAIT_DROP. c_addr/c_data stay stable until the next grant.
- WAIT_DROP:
  - c_ready=0 -> timer<=0, go to WAIT_RISE.
  - Otherwise timer++; when timer reaches ACK_TIMEOUT-1, go to DONE (write absorbed with no stall).
- WAIT_RISE:
  - c_ready=1 -> DONE.
  - Otherwise timer++; when timer reaches BUSY_TIMEOUT-1, go to ERR.
- DONE: req_done[grant_id]=1 for one cycle; go to IDLE.
- ERR: req_err[grant_id]=1 for one cycle; go to IDLE. The next IDLE grant still waits for c_ready=1.
- Timing:
  - Latency from grant to c_valid is 1 cycle.
  - Minimum grant-to-done time is 4 cycles (grant, ISSUE, WAIT_DROP sees low, WAIT_RISE sees high), then DONE.
  - Back-to-back grants are possible on the cycle after DONE.
- Timer width is clog2(max(ACK_TIMEOUT, BUSY_TIMEOUT))+1; the timer saturates and never wraps.
- A requester dropping req_valid before its req_ready cycle is not served and the pointer does not move.
- req_valid changes outside IDLE are ignored.
- Only one of req_done/req_err is ever high, and only for grant_id.
- Simultaneous requests: strict round-robin, so each requester is served at most once per N_REQ grants while others wait.

Test Plan:
- Single write, N_REQ=3: req_valid=3'b010, addr=2, data=0x5A; c_ready drops 2 cycles after c_valid and stays low 10 cycles -> req_ready[1]=1 once; c_valid=1 exactly one cycle with c_addr=2, c_data=0x5A; req_done[1] pulses; busy low afterwards.
- Fairness: req_valid=3'b111 held continuously, all writes complete normally -> grant order 0,1,2,0,1,2; each req_ready is one cycle.
- No-stall path: c_ready tied 1 -> req_done pulses in DONE after exactly 16 WAIT_DROP cycles (ACK_TIMEOUT=16), with no req_err.
- Stuck busy: c_ready held 0 after the drop -> req_err[g] pulses after 4096 WAIT_RISE cycles; no req_done; the next request waits until c_ready=1.
- Blocked start: c_ready=0 while req_valid=3'b001 -> req_ready stays 0 and c_valid stays 0; the grant occurs on the first cycle c_ready=1.
- Reset mid-transaction: assert rst in WAIT_RISE -> c_valid, busy, req_done and req_err are 0 immediately; after release, rr_ptr=0, so with req_valid=3'b110 the first grant goes to requester 1.
